// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared mode encodings and pointer helper for rr_arb_mux
//   MODE_FIXED / MODE_RR : values of the rr_arb_mux mode input
//   ptr_inc()            : round-robin pointer advance with wrap-around
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Pointer moves to the channel after the one just served, wrapping to 0.
  function automatic int ptr_inc(input int g, input int n_ch);
    return (g == n_ch - 1) ? 0 : g + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant selection
//   req     in   N_CH   request vector
//   ptr     in   CH_W   highest-priority channel this cycle
//   gnt_oh  out  N_CH   one-hot grant, zero when nothing is requested
//   gnt_idx out  CH_W   index of the granted channel (0 when no grant)
module rr_arbiter #(
  parameter int N_CH = 4,
  localparam int CH_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] ptr,
  output logic [N_CH-1:0] gnt_oh,
  output logic [CH_W-1:0] gnt_idx
);

  // Two copies of req side by side let a linear scan starting at ptr
  // cover the wrap-around without any modulo arithmetic.
  logic [2*N_CH-1:0] req2;
  logic [CH_W:0]     idx;
  logic              found;

  assign req2 = {req, req};

  always_comb begin
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int i = 0; i < N_CH; i++) begin
      idx = {1'b0, ptr} + (CH_W+1)'(i);
      if (!found && req2[idx]) begin
        found   = 1'b1;
        gnt_idx = (idx >= (CH_W+1)'(N_CH)) ? CH_W'(idx - (CH_W+1)'(N_CH)) : CH_W'(idx);
      end
    end
  end

  always_comb begin
    gnt_oh = '0;
    for (int c = 0; c < N_CH; c++) begin
      gnt_oh[c] = found && (gnt_idx == CH_W'(c));
    end
  end

endmodule

// File: rtl/rr_arb_mux.sv
// rtl/rr_arb_mux.sv - N-channel valid/ready mux with fixed or round-robin select
//   clk, rst   single clock, synchronous active-high reset
//   mode       0 = fixed (use sel), 1 = round-robin
//   sel        channel select in fixed mode
//   in_data    channel c at [c*W +: W]
//   in_valid   per-channel valid
//   in_ready   per-channel accept, one-hot or zero
//   out_data   registered output word
//   out_ch     source channel of out_data
//   out_valid  output register holds a word
//   out_ready  consumer accepts out_data
module rr_arb_mux
  import mux_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int W    = 8,
  localparam int CH_W = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic [CH_W-1:0]   sel,
  input  logic [N_CH*W-1:0] in_data,
  input  logic [N_CH-1:0]   in_valid,
  output logic [N_CH-1:0]   in_ready,
  output logic [W-1:0]      out_data,
  output logic [CH_W-1:0]   out_ch,
  output logic              out_valid,
  input  logic              out_ready
);

  logic [W-1:0]    out_data_q, out_data_d;
  logic [CH_W-1:0] out_ch_q, out_ch_d;
  logic            out_valid_q, out_valid_d;
  logic [CH_W-1:0] rr_ptr_q, rr_ptr_d;

  logic [N_CH-1:0] rr_gnt_oh;
  logic [CH_W-1:0] rr_gnt_idx;

  logic            load_en;
  logic            grant;
  logic [CH_W-1:0] g;
  logic [W-1:0]    g_data;
  logic            xfer;

  rr_arbiter #(.N_CH(N_CH)) u_arb (
    .req     (in_valid),
    .ptr     (rr_ptr_q),
    .gnt_oh  (rr_gnt_oh),
    .gnt_idx (rr_gnt_idx)
  );

  always_comb begin
    load_en = !out_valid_q || out_ready;
    grant   = 1'b0;
    g       = '0;
    if (mode == MODE_RR) begin
      grant = |rr_gnt_oh;
      g     = rr_gnt_idx;
    end else begin
      // Comparing against every legal index means a sel beyond N_CH-1
      // simply matches nothing and never grants.
      for (int c = 0; c < N_CH; c++) begin
        if (sel == CH_W'(c)) begin
          grant = in_valid[c];
          g     = sel;
        end
      end
    end
  end

  always_comb begin
    g_data   = '0;
    in_ready = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (g == CH_W'(c)) begin
        g_data = in_data[c*W +: W];
      end
      in_ready[c] = !rst && load_en && grant && (g == CH_W'(c));
    end
  end

  // grant already implies in_valid[g], so only the ready side is needed here.
  assign xfer = grant && load_en;

  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;
    if (load_en) begin
      if (xfer) begin
        out_data_d  = g_data;
        out_ch_d    = g;
        out_valid_d = 1'b1;
        if (mode == MODE_RR) begin
          rr_ptr_d = CH_W'(ptr_inc(int'(g), N_CH));
        end
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

endmodule
